// File: rtl/dds_serial_loader.sv
// dds_serial_loader: assembles a WORD_W-bit word from host chunks and shifts it LSB-first to the DDS pins; define DDS_INIT_SEQ_EN for the power-up init sequence
module dds_serial_loader #(
  parameter int WORD_W = 40,
  parameter int DATA_W = 16,
  parameter int DIV = 2,
  localparam int NCHUNK = (WORD_W + DATA_W - 1) / DATA_W,
  localparam int SEL_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic              dds_clk,
  input  logic              dds_reset,
  input  logic              dds_clken,
  input  logic              dds_load,
  input  logic [SEL_W-1:0]  dds_sel,
  input  logic [DATA_W-1:0] dds_datain,
  input  logic              dds_start,
  output logic              dds_busy,
  output logic              dds_done,
  output logic              ddswclk,
  output logic              ddsfqud,
  output logic              ddsreset,
  output logic              ddsdata
);
  localparam int BW = $clog2(WORD_W + 1);
  localparam int TW = $clog2(4 * DIV + 1);
`ifdef DDS_INIT_SEQ_EN
  typedef enum logic [3:0] {IDLE, BIT_LO, BIT_HI, FQUD, DONE, INIT_RST, INIT_LO, INIT_HI, INIT_FQ} state_t;
  localparam state_t RST_STATE = INIT_RST;
`else
  typedef enum logic [2:0] {IDLE, BIT_LO, BIT_HI, FQUD, DONE} state_t;
  localparam state_t RST_STATE = IDLE;
`endif
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, tick_max;
  logic [BW-1:0] bit_q, bit_d;
  logic [WORD_W-1:0] shift_q, shift_d, shadow_q, shadow_d;
  logic wclk_q, wclk_d, fqud_q, fqud_d, data_q, data_d, busy_q, busy_d, done_q, done_d;
  logic phase_end;
`ifdef DDS_INIT_SEQ_EN
  logic ddsrst_q, ddsrst_d;
  assign tick_max = (state_q == INIT_RST) ? TW'(4 * DIV - 1) : TW'(DIV - 1);
  assign ddsreset = ddsrst_q;
`else
  assign tick_max = TW'(DIV - 1);
  assign ddsreset = 1'b0;
`endif
  assign phase_end = timer_q == tick_max;
  assign dds_busy = busy_q;
  assign dds_done = done_q;
  assign ddswclk = wclk_q;
  assign ddsfqud = fqud_q;
  assign ddsdata = data_q;
  // shadow write: out-of-range selects match no bit, bits past WORD_W-1 are never addressed
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < WORD_W; i++)
      if (dds_load && int'(dds_sel) == i / DATA_W) shadow_d[i] = dds_datain[i % DATA_W];
  end
  // next state: DONE always exits, everything else moves only on enabled ticks
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d = bit_q;
    shift_d = shift_q;
    if (state_q == DONE) state_d = IDLE;
    else if (dds_clken && state_q == IDLE) begin
      if (dds_start) begin
        state_d = BIT_LO;
        timer_d = '0;
        bit_d = '0;
        shift_d = shadow_d;
      end
    end else if (dds_clken && !phase_end) timer_d = timer_q + 1'b1;
    else if (dds_clken) begin
      timer_d = '0;
      case (state_q)
        BIT_LO: state_d = BIT_HI;
        BIT_HI: begin
          state_d = (bit_q == BW'(WORD_W - 1)) ? FQUD : BIT_LO;
          bit_d = (bit_q == BW'(WORD_W)) ? bit_q : bit_q + 1'b1;
          shift_d = shift_q >> 1;
        end
        FQUD: state_d = DONE;
`ifdef DDS_INIT_SEQ_EN
        INIT_RST: state_d = INIT_LO;
        INIT_LO: state_d = INIT_HI;
        INIT_HI: state_d = INIT_FQ;
        INIT_FQ: state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end
  // pin and status values decoded from the current state, registered one cycle later
  always_comb begin
    busy_d = state_q != IDLE && state_q != DONE;
    done_d = state_q == DONE;
    data_d = (state_q == BIT_LO) ? shift_q[0] : data_q;
`ifdef DDS_INIT_SEQ_EN
    wclk_d = state_q inside {BIT_HI, INIT_HI};
    fqud_d = state_q inside {FQUD, INIT_FQ};
    ddsrst_d = state_q == INIT_RST;
`else
    wclk_d = state_q == BIT_HI;
    fqud_d = state_q == FQUD;
`endif
  end
  // state, datapath and output registers; reset also clears the shadow
  always_ff @(posedge dds_clk) begin
    if (dds_reset) begin
      state_q <= RST_STATE;
      timer_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      shadow_q <= '0;
      wclk_q <= 1'b0;
      fqud_q <= 1'b0;
      data_q <= 1'b0;
      done_q <= 1'b0;
`ifdef DDS_INIT_SEQ_EN
      busy_q <= 1'b1;
      ddsrst_q <= 1'b1;
`else
      busy_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      shadow_q <= shadow_d;
      wclk_q <= wclk_d;
      fqud_q <= fqud_d;
      data_q <= data_d;
      done_q <= done_d;
      busy_q <= busy_d;
`ifdef DDS_INIT_SEQ_EN
      ddsrst_q <= ddsrst_d;
`endif
    end
  end
endmodule

// File: tb/tb_dds_serial_loader.sv
// tb_dds_serial_loader: directed and random transfers checked against a chunk-level word model
module tb_dds_serial_loader;
  logic dds_clk = 1'b0;
  logic dds_reset, dds_clken, dds_load, dds_start;
  logic [1:0] dds_sel;
  logic [15:0] dds_datain;
  logic dds_busy, dds_done, ddswclk, ddsfqud, ddsreset, ddsdata;
  int passes = 0;
  int total = 0;
  int per = 1;
  int phase = 0;
  logic [15:0] chunk_m [3];

  dds_serial_loader dut (
    .dds_clk(dds_clk), .dds_reset(dds_reset), .dds_clken(dds_clken), .dds_load(dds_load),
    .dds_sel(dds_sel), .dds_datain(dds_datain), .dds_start(dds_start), .dds_busy(dds_busy),
    .dds_done(dds_done), .ddswclk(ddswclk), .ddsfqud(ddsfqud), .ddsreset(ddsreset), .ddsdata(ddsdata)
  );

  always #5 dds_clk = ~dds_clk;

  function automatic logic [39:0] model_word();
    return {chunk_m[2][7:0], chunk_m[1], chunk_m[0]};
  endfunction

  task automatic model_load(input logic [1:0] s, input logic [15:0] d);
    if (s < 2'd3) chunk_m[s] = d;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    dds_clken = (phase == 0);
    phase = (phase + 1) % per;
    @(posedge dds_clk);
    #1;
  endtask

  task automatic load(input logic [1:0] s, input logic [15:0] d);
    dds_load = 1'b1;
    dds_sel = s;
    dds_datain = d;
    model_load(s, d);
    step();
    dds_load = 1'b0;
  endtask

  task automatic xfer(input string tag, input bit byp, input logic [1:0] bs, input logic [15:0] bd, input bit disturb);
    logic [39:0] exp_w, got;
    int nb, busy_n, done_at, done_n, fq_n, fq_pulses, wbad, dbad, hi_run, n;
    logic pw, pf, pd;
    while (phase != 0) step();
    if (byp) begin
      dds_load = 1'b1;
      dds_sel = bs;
      dds_datain = bd;
      model_load(bs, bd);
    end
    exp_w = model_word();
    dds_start = 1'b1;
    step();
    dds_start = 1'b0;
    dds_load = 1'b0;
    got = '0;
    nb = 0; busy_n = 0; done_at = 0; done_n = 0; fq_n = 0; fq_pulses = 0; wbad = 0; dbad = 0; hi_run = 0;
    pw = ddswclk; pf = ddsfqud; pd = ddsdata;
    for (n = 1; n <= 170 * per + 10 && !(done_at != 0 && n > done_at + 8); n++) begin
      if (disturb && n == 50) begin
        dds_start = 1'b1;
        dds_load = 1'b1;
        dds_sel = 2'd0;
        dds_datain = 16'hFFFF;
        model_load(2'd0, 16'hFFFF);
      end
      step();
      dds_start = 1'b0;
      dds_load = 1'b0;
      if (n == 1) begin
        chk({tag, "_first_bit"}, ddsdata, exp_w[0]);
        chk({tag, "_busy_rise"}, dds_busy, 1);
      end
      busy_n += dds_busy;
      if (dds_done) begin
        done_n++;
        if (done_at == 0) done_at = n;
      end
      if (ddswclk && !pw) begin
        if (nb < 40) got[nb] = ddsdata;
        nb++;
      end
      if (ddswclk) hi_run++;
      else if (pw) begin
        if (hi_run != 2 * per) wbad++;
        hi_run = 0;
      end
      if (ddswclk && ddsdata !== pd) dbad++;
      if (ddsfqud) begin
        fq_n++;
        if (ddswclk) wbad++;
      end
      if (ddsfqud && !pf) fq_pulses++;
      pw = ddswclk; pf = ddsfqud; pd = ddsdata;
    end
    chk({tag, "_word"}, got, exp_w);
    chk({tag, "_nbits"}, nb, 40);
    chk({tag, "_busy_cycles"}, busy_n, 162 * per);
    chk({tag, "_done_at"}, done_at, 162 * per + 1);
    chk({tag, "_done_width"}, done_n, 1);
    chk({tag, "_fqud_pulses"}, fq_pulses, 1);
    chk({tag, "_fqud_len"}, fq_n, 2 * per);
    chk({tag, "_wclk_shape"}, wbad, 0);
    chk({tag, "_data_stable"}, dbad, 0);
  endtask

  initial begin
    int nb;
    logic pw;
    dds_reset = 1'b1;
    dds_clken = 1'b1;
    dds_load = 1'b0;
    dds_start = 1'b0;
    dds_sel = 2'd0;
    dds_datain = 16'h0;
    for (int i = 0; i < 3; i++) chunk_m[i] = 16'h0;
    repeat (3) step();
    chk("rst_wclk", ddswclk, 0);
    chk("rst_fqud", ddsfqud, 0);
    chk("rst_data", ddsdata, 0);
    chk("rst_done", dds_done, 0);
`ifdef DDS_INIT_SEQ_EN
    chk("rst_busy", dds_busy, 1);
    chk("rst_ddsreset", ddsreset, 1);
`else
    chk("rst_busy", dds_busy, 0);
    chk("rst_ddsreset", ddsreset, 0);
`endif
    dds_reset = 1'b0;
`ifdef DDS_INIT_SEQ_EN
    begin
      int rst_n, wclk_n, fq_n, done_n;
      rst_n = 0; wclk_n = 0; fq_n = 0; done_n = 0;
      for (int n = 1; n <= 30; n++) begin
        dds_start = (n == 3);
        step();
        dds_start = 1'b0;
        rst_n += ddsreset;
        wclk_n += ddswclk;
        fq_n += ddsfqud;
        done_n += dds_done;
      end
      chk("init_reset_len", rst_n, 8);
      chk("init_wclk_len", wclk_n, 2);
      chk("init_fqud_len", fq_n, 2);
      chk("init_no_done", done_n, 0);
      chk("init_end_busy", dds_busy, 0);
    end
`endif
    load(2'd0, 16'h1234);
    load(2'd1, 16'h5678);
    load(2'd2, 16'h00AB);
    xfer("basic", 1'b0, 2'd0, 16'h0, 1'b0);
    per = 3;
    phase = 0;
    xfer("clken3", 1'b0, 2'd0, 16'h0, 1'b0);
    per = 1;
    phase = 0;
    xfer("disturb", 1'b0, 2'd0, 16'h0, 1'b1);
    xfer("after_disturb", 1'b0, 2'd0, 16'h0, 1'b0);
    load(2'd3, 16'hDEAD);
    xfer("bypass", 1'b1, 2'd0, 16'h0001, 1'b0);
    for (int r = 0; r < 3; r++) begin
      repeat (4) load(2'($urandom_range(0, 3)), 16'($urandom));
      xfer("rand", 1'b0, 2'd0, 16'h0, 1'b0);
    end
    dds_start = 1'b1;
    step();
    dds_start = 1'b0;
    nb = 0;
    pw = ddswclk;
    for (int n = 0; n < 1000 && nb < 17; n++) begin
      step();
      if (ddswclk && !pw) nb++;
      pw = ddswclk;
    end
    chk("abort_reached_bit17", nb, 17);
    dds_reset = 1'b1;
    step();
    dds_reset = 1'b0;
    for (int i = 0; i < 3; i++) chunk_m[i] = 16'h0;
    chk("abort_wclk", ddswclk, 0);
    chk("abort_fqud", ddsfqud, 0);
    chk("abort_data", ddsdata, 0);
    chk("abort_done", dds_done, 0);
`ifdef DDS_INIT_SEQ_EN
    chk("abort_busy", dds_busy, 1);
    repeat (30) step();
`else
    chk("abort_busy", dds_busy, 0);
    chk("abort_ddsreset", ddsreset, 0);
`endif
    xfer("zero", 1'b0, 2'd0, 16'h0, 1'b0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
